axil_regfile_slave: RTL and testbench

- AXI4-Lite slave front end for the DMA control register file.
- Terminates the CPU-facing AXI4-Lite channels and converts them into the register file's single write port and single read port, including its ready signals and 1-cycle read latency.
- Sits directly upstream of the register file. Its rf_* outputs drive the register file's slave port; the main FSM read ports are untouched.

---
 rtl/dma_axi_pkg.sv | 41 ++++
 rtl/axil_regfile_slave.sv | 136 +++++++++++++
 tb/tb_axil_regfile_slave.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_axi_pkg.sv
// Shared types and helpers for the DMA register-file AXI4-Lite front end.
// Holds the response codes, both FSM state enums and the address decoder.
package dma_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_WRITE,
      W_RESP
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ISSUE,
      R_RESP
   } rd_state_t;

   typedef struct packed {
      logic        err;
      logic [63:0] idx;
   } addr_chk_t;

   // Widths are passed in so one decoder serves any parameterisation of the slave.
   function automatic addr_chk_t addr_check(input logic [63:0] addr,
                                            input int          idx_bits,
                                            input int          offs);
      addr_chk_t   r;
      logic [63:0] low_mask;
      logic [63:0] idx_mask;
      low_mask = (64'd1 << offs) - 64'd1;
      idx_mask = (64'd1 << idx_bits) - 64'd1;
      r.idx    = (addr >> offs) & idx_mask;
      r.err    = ((addr & low_mask) != 64'd0) || ((addr >> (idx_bits + offs)) != 64'd0);
      return r;
   endfunction

endpackage

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave that turns CPU register accesses into the register file's
// single write port and single 1-cycle-latency read port.
module axil_regfile_slave
   import dma_axi_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int AXI_ADDR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
   input  logic                      s_awvalid,
   output logic                      s_awready,
   input  logic [DATA_WIDTH-1:0]     s_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
   input  logic                      s_wvalid,
   output logic                      s_wready,
   output logic [1:0]                s_bresp,
   output logic                      s_bvalid,
   input  logic                      s_bready,
   input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
   input  logic                      s_arvalid,
   output logic                      s_arready,
   output logic [DATA_WIDTH-1:0]     s_rdata,
   output logic [1:0]                s_rresp,
   output logic                      s_rvalid,
   input  logic                      s_rready,
   output logic                      rf_write_enable,
   output logic [DATA_WIDTH-1:0]     rf_datain,
   output logic [ADDR_WIDTH-1:0]     rf_writeAddr,
   input  logic                      rf_writeReady,
   output logic                      rf_read_enable,
   output logic [ADDR_WIDTH-1:0]     rf_readAddr,
   input  logic [DATA_WIDTH-1:0]     rf_dataout,
   input  logic                      rf_readReady
);

   localparam int OFFS       = $clog2(DATA_WIDTH/8);
   localparam int STRB_WIDTH = DATA_WIDTH/8;

   wr_state_t w_state, w_next;
   rd_state_t r_state, r_next;
   addr_chk_t aw_chk, ar_chk;
   logic      aw_hs, w_hs, ar_hs;
   logic      aw_err, strb_err, ar_err, w_err;

   assign aw_chk = addr_check(64'(s_awaddr), ADDR_WIDTH, OFFS);
   assign ar_chk = addr_check(64'(s_araddr), ADDR_WIDTH, OFFS);
   assign aw_hs  = s_awvalid && s_awready;
   assign w_hs   = s_wvalid && s_wready;
   assign ar_hs  = s_arvalid && s_arready;
   assign w_err  = aw_err || strb_err;

   // Readies are registered from the next state, so they track the state one-for-one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_state      <= W_IDLE;
         s_awready    <= 1'b0;
         s_wready     <= 1'b0;
         aw_err       <= 1'b0;
         strb_err     <= 1'b0;
         rf_writeAddr <= '0;
         rf_datain    <= '0;
      end else begin
         w_state   <= w_next;
         s_awready <= (w_next == W_IDLE) || (w_next == W_HAVE_W);
         s_wready  <= (w_next == W_IDLE) || (w_next == W_HAVE_AW);
         if (aw_hs) begin
            aw_err       <= aw_chk.err;
            rf_writeAddr <= ADDR_WIDTH'(aw_chk.idx);
         end
         if (w_hs) begin
            rf_datain <= s_wdata;
            strb_err  <= (s_wstrb != {STRB_WIDTH{1'b1}});
         end
      end
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) w_next = W_WRITE;
            else if (aw_hs)    w_next = W_HAVE_AW;
            else if (w_hs)     w_next = W_HAVE_W;
         end
         W_HAVE_AW: if (w_hs)                    w_next = W_WRITE;
         W_HAVE_W:  if (aw_hs)                   w_next = W_WRITE;
         W_WRITE:   if (w_err || rf_writeReady)  w_next = W_RESP;
         W_RESP:    if (s_bready)                w_next = W_IDLE;
         default:                                w_next = W_IDLE;
      endcase
   end

   always_comb begin
      rf_write_enable = (w_state == W_WRITE) && !w_err && rf_writeReady;
      s_bvalid        = (w_state == W_RESP);
      s_bresp         = (s_bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= R_IDLE;
         s_arready   <= 1'b0;
         ar_err      <= 1'b0;
         rf_readAddr <= '0;
      end else begin
         r_state   <= r_next;
         s_arready <= (r_next == R_IDLE);
         if (ar_hs) begin
            ar_err      <= ar_chk.err;
            rf_readAddr <= ADDR_WIDTH'(ar_chk.idx);
         end
      end
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs)                   r_next = R_ISSUE;
         R_ISSUE: if (ar_err || rf_readReady)  r_next = R_RESP;
         R_RESP:  if (s_rready)                r_next = R_IDLE;
         default:                              r_next = R_IDLE;
      endcase
   end

   // rf_dataout stays valid through R_RESP because no further read is issued.
   always_comb begin
      rf_read_enable = (r_state == R_ISSUE) && !ar_err && rf_readReady;
      s_rvalid       = (r_state == R_RESP);
      s_rdata        = (s_rvalid && !ar_err) ? rf_dataout : '0;
      s_rresp        = (s_rvalid && ar_err) ? RESP_SLVERR : RESP_OKAY;
   end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Directed bench for axil_regfile_slave with a behavioural register file
// that answers reads one cycle after rf_read_enable.
module tb_axil_regfile_slave;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] s_awaddr = '0;
   logic        s_awvalid = 1'b0;
   logic        s_awready;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_wvalid = 1'b0;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready = 1'b0;
   logic [31:0] s_araddr = '0;
   logic        s_arvalid = 1'b0;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready = 1'b0;
   logic        rf_write_enable;
   logic [31:0] rf_datain;
   logic [7:0]  rf_writeAddr;
   logic        rf_writeReady = 1'b1;
   logic        rf_read_enable;
   logic [7:0]  rf_readAddr;
   logic [31:0] rf_dataout = '0;
   logic        rf_readReady = 1'b1;

   logic [31:0] mem [256];
   int          write_count = 0;
   int          compared = 0;
   int          mismatched = 0;

   axil_regfile_slave #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(8),
      .AXI_ADDR_WIDTH(32)
   ) dut (
      .clk(clk),
      .reset(reset),
      .s_awaddr(s_awaddr),
      .s_awvalid(s_awvalid),
      .s_awready(s_awready),
      .s_wdata(s_wdata),
      .s_wstrb(s_wstrb),
      .s_wvalid(s_wvalid),
      .s_wready(s_wready),
      .s_bresp(s_bresp),
      .s_bvalid(s_bvalid),
      .s_bready(s_bready),
      .s_araddr(s_araddr),
      .s_arvalid(s_arvalid),
      .s_arready(s_arready),
      .s_rdata(s_rdata),
      .s_rresp(s_rresp),
      .s_rvalid(s_rvalid),
      .s_rready(s_rready),
      .rf_write_enable(rf_write_enable),
      .rf_datain(rf_datain),
      .rf_writeAddr(rf_writeAddr),
      .rf_writeReady(rf_writeReady),
      .rf_read_enable(rf_read_enable),
      .rf_readAddr(rf_readAddr),
      .rf_dataout(rf_dataout),
      .rf_readReady(rf_readReady)
   );

   always #5 clk = ~clk;

   // Register file model: a read issued alongside a write returns the old word.
   always @(posedge clk) begin
      if (rf_read_enable) rf_dataout <= mem[rf_readAddr];
      if (rf_write_enable) begin
         mem[rf_writeAddr] <= rf_datain;
         write_count       <= write_count + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Full write with AW and W presented together, checking the rf strobe and response.
   task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb,
                                input logic exp_en, input logic [7:0] exp_idx,
                                input logic [1:0] exp_resp);
      s_awaddr  = addr;
      s_wdata   = data;
      s_wstrb   = strb;
      s_awvalid = 1'b1;
      s_wvalid  = 1'b1;
      step();
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      checkOutput({tag, "_wen"}, 32'(rf_write_enable), 32'(exp_en));
      if (exp_en) begin
         checkOutput({tag, "_widx"}, 32'(rf_writeAddr), 32'(exp_idx));
         checkOutput({tag, "_wdat"}, rf_datain, data);
      end
      step();
      checkOutput({tag, "_bvalid"}, 32'(s_bvalid), 32'd1);
      checkOutput({tag, "_bresp"}, 32'(s_bresp), 32'(exp_resp));
      s_bready = 1'b1;
      step();
      s_bready = 1'b0;
      checkOutput({tag, "_bdone"}, 32'(s_bvalid), 32'd0);
   endtask

   task automatic doRead(input string tag, input logic [31:0] addr, input logic exp_en,
                         input logic [7:0] exp_idx, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp);
      s_araddr  = addr;
      s_arvalid = 1'b1;
      step();
      s_arvalid = 1'b0;
      checkOutput({tag, "_ren"}, 32'(rf_read_enable), 32'(exp_en));
      if (exp_en) checkOutput({tag, "_ridx"}, 32'(rf_readAddr), 32'(exp_idx));
      step();
      checkOutput({tag, "_rvalid"}, 32'(s_rvalid), 32'd1);
      checkOutput({tag, "_rdata"}, s_rdata, exp_data);
      checkOutput({tag, "_rresp"}, 32'(s_rresp), 32'(exp_resp));
      s_rready = 1'b1;
      step();
      s_rready = 1'b0;
      checkOutput({tag, "_rdone"}, 32'(s_rvalid), 32'd0);
   endtask

   initial begin
      // Reset state
      step();
      step();
      checkOutput("rst_awready", 32'(s_awready), 32'd0);
      checkOutput("rst_wready", 32'(s_wready), 32'd0);
      checkOutput("rst_arready", 32'(s_arready), 32'd0);
      checkOutput("rst_bvalid", 32'(s_bvalid), 32'd0);
      checkOutput("rst_rvalid", 32'(s_rvalid), 32'd0);
      checkOutput("rst_wen", 32'(rf_write_enable), 32'd0);
      checkOutput("rst_waddr", 32'(rf_writeAddr), 32'd0);
      reset = 1'b0;
      checkOutput("rel_awready0", 32'(s_awready), 32'd0);
      step();
      checkOutput("rel_awready1", 32'(s_awready), 32'd1);
      checkOutput("rel_arready1", 32'(s_arready), 32'd1);

      // 1: AW and W together
      applyStimulus("t1", 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 8'd4, 2'b00);
      checkOutput("t1_count", 32'(write_count), 32'd1);

      // 2: W first, AW three cycles later
      s_wdata  = 32'h12345678;
      s_wstrb  = 4'hF;
      s_wvalid = 1'b1;
      step();
      s_wvalid = 1'b0;
      checkOutput("t2_wready_lo", 32'(s_wready), 32'd0);
      checkOutput("t2_awready_hi", 32'(s_awready), 32'd1);
      step();
      checkOutput("t2_wready_lo2", 32'(s_wready), 32'd0);
      checkOutput("t2_wen_idle", 32'(rf_write_enable), 32'd0);
      step();
      s_awaddr  = 32'h08;
      s_awvalid = 1'b1;
      step();
      s_awvalid = 1'b0;
      checkOutput("t2_wen", 32'(rf_write_enable), 32'd1);
      checkOutput("t2_widx", 32'(rf_writeAddr), 32'd2);
      checkOutput("t2_wdat", rf_datain, 32'h12345678);
      step();
      checkOutput("t2_bvalid", 32'(s_bvalid), 32'd1);
      checkOutput("t2_bresp", 32'(s_bresp), 32'd0);
      checkOutput("t2_count", 32'(write_count), 32'd2);
      s_bready = 1'b1;
      step();
      s_bready = 1'b0;

      // 3: read back index 4 with a stalled rready
      s_araddr  = 32'h10;
      s_arvalid = 1'b1;
      step();
      s_arvalid = 1'b0;
      checkOutput("t3_ren", 32'(rf_read_enable), 32'd1);
      checkOutput("t3_ridx", 32'(rf_readAddr), 32'd4);
      checkOutput("t3_rvalid_early", 32'(s_rvalid), 32'd0);
      step();
      for (int i = 0; i < 5; i++) begin
         checkOutput("t3_rvalid_hold", 32'(s_rvalid), 32'd1);
         checkOutput("t3_rdata_hold", s_rdata, 32'hDEADBEEF);
         checkOutput("t3_ren_quiet", 32'(rf_read_enable), 32'd0);
         step();
      end
      checkOutput("t3_rresp", 32'(s_rresp), 32'd0);
      s_rready = 1'b1;
      step();
      s_rready = 1'b0;
      checkOutput("t3_rdone", 32'(s_rvalid), 32'd0);
      doRead("t3b", 32'h08, 1'b1, 8'd2, 32'h12345678, 2'b00);

      // 4: error cases
      applyStimulus("t4_mis", 32'h11, 32'h11111111, 4'hF, 1'b0, 8'd0, 2'b10);
      applyStimulus("t4_oor", 32'h400, 32'h22222222, 4'hF, 1'b0, 8'd0, 2'b10);
      applyStimulus("t4_strb", 32'h0C, 32'h33333333, 4'h3, 1'b0, 8'd0, 2'b10);
      checkOutput("t4_count", 32'(write_count), 32'd2);
      doRead("t4_rd", 32'h400, 1'b0, 8'd0, 32'h0, 2'b10);

      // 5: register file not ready for four cycles
      rf_writeReady = 1'b0;
      s_awaddr  = 32'h20;
      s_wdata   = 32'hCAFEF00D;
      s_wstrb   = 4'hF;
      s_awvalid = 1'b1;
      s_wvalid  = 1'b1;
      step();
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checkOutput("t5_wen_stall", 32'(rf_write_enable), 32'd0);
         checkOutput("t5_bvalid_stall", 32'(s_bvalid), 32'd0);
         step();
      end
      rf_writeReady = 1'b1;
      #1;
      checkOutput("t5_wen", 32'(rf_write_enable), 32'd1);
      checkOutput("t5_widx", 32'(rf_writeAddr), 32'd8);
      step();
      checkOutput("t5_bvalid", 32'(s_bvalid), 32'd1);
      checkOutput("t5_count", 32'(write_count), 32'd3);
      s_bready = 1'b1;
      step();
      s_bready = 1'b0;

      // 6: reset while the response is pending
      s_awaddr  = 32'h30;
      s_wdata   = 32'h00000055;
      s_awvalid = 1'b1;
      s_wvalid  = 1'b1;
      step();
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      step();
      checkOutput("t6_bvalid_pre", 32'(s_bvalid), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("t6_bvalid_rst", 32'(s_bvalid), 32'd0);
      checkOutput("t6_awready_rst", 32'(s_awready), 32'd0);
      step();
      step();
      reset = 1'b0;
      checkOutput("t6_wready_rel0", 32'(s_wready), 32'd0);
      step();
      checkOutput("t6_awready_rel1", 32'(s_awready), 32'd1);
      checkOutput("t6_wready_rel1", 32'(s_wready), 32'd1);
      checkOutput("t6_arready_rel1", 32'(s_arready), 32'd1);
      step();
      step();
      checkOutput("t6_wen_quiet", 32'(rf_write_enable), 32'd0);
      checkOutput("t6_count", 32'(write_count), 32'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
